// File: rtl/dma_request_scheduler.sv
// DMA request scheduler: HRQ/HLDA bus-hold handshake, fixed or rotating channel arbitration, one-hot DACK.
// Optional software request register enabled by defining DMA_SCHED_SW_REQ_EN.
module dma_request_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] dreq,
    input  logic [NUM_CH-1:0] mask,
    input  logic              rot_mode,
    input  logic              hlda,
    input  logic              xfer_done,
    input  logic [NUM_CH-1:0] sw_req_set,
    output logic              hrq,
    output logic [NUM_CH-1:0] dack,
    output logic              grant_valid,
    output logic [CH_W-1:0]   grant_ch,
    output logic              abort,
    output logic [NUM_CH-1:0] sw_req_pending
);

    typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   grant_ch_q, grant_ch_d;
    logic [CH_W-1:0]   prio_ptr_q, prio_ptr_d;
    logic              hrq_q, hrq_d;
    logic [NUM_CH-1:0] dack_q, dack_d;
    logic              grant_valid_q, grant_valid_d;
    logic              abort_q, abort_d;
    logic [NUM_CH-1:0] sw_req_pending_q, sw_req_pending_d;
    logic [NUM_CH-1:0] sw_clr;

    logic [NUM_CH-1:0] eff;
    logic [CH_W-1:0]   base, arb_ch, idx;
    logic [CH_W:0]     sum;
    logic              arb_found;

    assign eff = (dreq & ~mask) | sw_req_pending_q;

    // Round-robin scan starting at base; fixed mode always starts at channel 0.
    always_comb begin
        base      = rot_mode ? prio_ptr_q : '0;
        arb_ch    = '0;
        arb_found = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, base} + (CH_W+1)'(i);
            if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
            idx = sum[CH_W-1:0];
            if (!arb_found && eff[idx]) begin
                arb_found = 1'b1;
                arb_ch    = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_ch_d    = grant_ch_q;
        prio_ptr_d    = prio_ptr_q;
        hrq_d         = hrq_q;
        dack_d        = dack_q;
        grant_valid_d = grant_valid_q;
        abort_d       = 1'b0;
        sw_clr        = '0;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_ch_d = arb_ch;
                    hrq_d      = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // A vanished request cancels even if hlda arrives the same cycle.
                if (!eff[grant_ch_q]) begin
                    hrq_d   = 1'b0;
                    state_d = RELEASE;
                end else if (hlda) begin
                    dack_d        = {{(NUM_CH-1){1'b0}}, 1'b1} << grant_ch_q;
                    grant_valid_d = 1'b1;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                if (xfer_done) begin
                    dack_d             = '0;
                    grant_valid_d      = 1'b0;
                    hrq_d              = 1'b0;
                    sw_clr[grant_ch_q] = 1'b1;
                    if (rot_mode)
                        prio_ptr_d = (grant_ch_q == CH_W'(NUM_CH-1)) ? '0 : grant_ch_q + 1'b1;
                    state_d = RELEASE;
                end else if (!hlda) begin
                    // Pointer and sw bit are kept so the aborted channel re-arbitrates.
                    dack_d        = '0;
                    grant_valid_d = 1'b0;
                    hrq_d         = 1'b0;
                    abort_d       = 1'b1;
                    state_d       = RELEASE;
                end
            end
            RELEASE: begin
                if (!hlda) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef DMA_SCHED_SW_REQ_EN
        sw_req_pending_d = (sw_req_pending_q & ~sw_clr) | sw_req_set;
`else
        sw_req_pending_d = '0;
`endif
    end

`ifndef DMA_SCHED_SW_REQ_EN
    logic unused_sw;
    assign unused_sw = ^{sw_req_set, sw_clr};
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q          <= IDLE;
            grant_ch_q       <= '0;
            prio_ptr_q       <= '0;
            hrq_q            <= 1'b0;
            dack_q           <= '0;
            grant_valid_q    <= 1'b0;
            abort_q          <= 1'b0;
            sw_req_pending_q <= '0;
        end else begin
            state_q          <= state_d;
            grant_ch_q       <= grant_ch_d;
            prio_ptr_q       <= prio_ptr_d;
            hrq_q            <= hrq_d;
            dack_q           <= dack_d;
            grant_valid_q    <= grant_valid_d;
            abort_q          <= abort_d;
            sw_req_pending_q <= sw_req_pending_d;
        end
    end

    assign hrq            = hrq_q;
    assign dack           = dack_q;
    assign grant_valid    = grant_valid_q;
    assign grant_ch       = grant_ch_q;
    assign abort          = abort_q;
    assign sw_req_pending = sw_req_pending_q;

endmodule
